// File: rtl/solver_pkg.sv
// Shared types for the solver dispatcher: per-slot and dispatch FSM encodings
// plus the iteration-count sentinel reported when a pixel hits the limit.
package solver_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_LOADING = 2'd1,
        SLOT_BUSY    = 2'd2,
        SLOT_DONE    = 2'd3
    } slot_state_t;

    typedef enum logic [1:0] {
        DISPATCH_IDLE  = 2'd0,
        DISPATCH_LOAD  = 2'd1,
        DISPATCH_START = 2'd2
    } dispatch_state_t;

    localparam int COUNT_BITS = 16;
    localparam logic [15:0] ITER_LIMIT_HIT = 16'hFFFF;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
// N must be a power of two so the pointer arithmetic wraps naturally.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic [IW-1:0] cand_s;

    // Scan from the pointer and keep the first hit
    always_comb begin
        valid  = 1'b0;
        index  = {IW{1'b0}};
        cand_s = {IW{1'b0}};
        for (int k = 0; k < N; k++) begin
            cand_s = ptr + IW'(k);
            if (!valid && req[cand_s]) begin
                valid = 1'b1;
                index = cand_s;
            end else begin
                valid = valid;
            end
        end
        if (valid) begin
            grant = {{(N-1){1'b0}}, 1'b1} << index;
        end else begin
            grant = {N{1'b0}};
        end
    end

endmodule

// File: rtl/solver_dispatch.sv
// Shares NUM_SOLVERS fractal solver cores between one job stream: broadcasts
// configuration, loads/starts jobs on free cores, and collects tagged results.
module solver_dispatch
    import solver_pkg::*;
#(
    parameter int NUM_SOLVERS     = 4,
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32,
    parameter int TAG_BITS        = 16
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               cfg_wr_en,
    input  logic [LIMB_INDEX_BITS-1:0]         cfg_num_limbs,
    input  logic [15:0]                        cfg_iter_lim,
    output logic                               cfg_busy,
    input  logic                               job_valid,
    output logic                               job_ready,
    input  logic [TAG_BITS-1:0]                job_tag,
    input  logic                               limb_valid,
    output logic                               limb_ready,
    input  logic [LIMB_BITS-1:0]               limb_cre,
    input  logic [LIMB_BITS-1:0]               limb_cim,
    output logic                               sol_wr_num_limbs_en,
    output logic [LIMB_INDEX_BITS-1:0]         sol_num_limbs,
    output logic                               sol_wr_iter_lim_en,
    output logic [15:0]                        sol_iter_lim,
    output logic [NUM_SOLVERS-1:0]             sol_wr_en,
    output logic [LIMB_INDEX_BITS-1:0]         sol_wr_limb,
    output logic [LIMB_BITS-1:0]               sol_cre,
    output logic [LIMB_BITS-1:0]               sol_cim,
    output logic [NUM_SOLVERS-1:0]             sol_start,
    input  logic [NUM_SOLVERS-1:0]             sol_out_ready,
    input  logic [COUNT_BITS*NUM_SOLVERS-1:0]  sol_iter_count,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [TAG_BITS-1:0]                res_tag,
    output logic [15:0]                        res_count
);

    localparam int IW = $clog2(NUM_SOLVERS);
    localparam logic [NUM_SOLVERS-1:0] ONE_HOT_0 = {{(NUM_SOLVERS-1){1'b0}}, 1'b1};

    dispatch_state_t                state_r, state_next_s;
    slot_state_t                    slot_r [NUM_SOLVERS];
    logic [TAG_BITS-1:0]            tag_r  [NUM_SOLVERS];
    logic [NUM_SOLVERS-1:0]         idle_vec_s, done_vec_s, rise_s, out_ready_d_r;
    logic [NUM_SOLVERS-1:0]         idle_grant_s, done_grant_s;
    logic [NUM_SOLVERS-1:0]         wr_en_s, start_s;
    logic                           idle_valid_s, done_valid_s;
    logic [IW-1:0]                  idle_idx_s, done_idx_s;
    logic [IW-1:0]                  disp_ptr_r, coll_ptr_r, slot_sel_r;
    logic [LIMB_INDEX_BITS-1:0]     limb_cnt_r, num_limbs_r;
    logic [15:0]                    iter_lim_r;
    logic                           cfg_pulse_r, cfg_busy_s, cfg_accept_s;
    logic                           job_ready_s, limb_ready_s;
    logic                           job_accept_s, limb_beat_s, last_beat_s;
    logic                           res_free_s, load_res_s;
    logic                           res_valid_r;
    logic [TAG_BITS-1:0]            res_tag_r;
    logic [15:0]                    res_count_r;

    // Slot occupancy vectors feeding the two round-robin pickers
    always_comb begin
        idle_vec_s = {NUM_SOLVERS{1'b0}};
        done_vec_s = {NUM_SOLVERS{1'b0}};
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            idle_vec_s[i] = (slot_r[i] == SLOT_IDLE);
            done_vec_s[i] = (slot_r[i] == SLOT_DONE);
        end
    end

    rr_pick #(.N(NUM_SOLVERS)) u_idle_pick (
        .req   (idle_vec_s),
        .ptr   (disp_ptr_r),
        .valid (idle_valid_s),
        .grant (idle_grant_s),
        .index (idle_idx_s)
    );

    rr_pick #(.N(NUM_SOLVERS)) u_done_pick (
        .req   (done_vec_s),
        .ptr   (coll_ptr_r),
        .valid (done_valid_s),
        .grant (done_grant_s),
        .index (done_idx_s)
    );

    assign cfg_busy_s   = (state_r != DISPATCH_IDLE) || (idle_vec_s != {NUM_SOLVERS{1'b1}});
    assign cfg_accept_s = cfg_wr_en && !cfg_busy_s;
    assign job_accept_s = job_valid && job_ready_s;
    assign limb_beat_s  = limb_valid && limb_ready_s;
    assign last_beat_s  = limb_beat_s && (limb_cnt_r == (num_limbs_r - LIMB_INDEX_BITS'(1)));
    assign rise_s       = sol_out_ready & ~out_ready_d_r;
    assign res_free_s   = !res_valid_r || res_ready;
    assign load_res_s   = res_free_s && done_valid_s;

    // Configuration latch; zero limbs is meaningless and is clamped to one
    always_ff @(posedge clock) begin
        if (!reset) begin
            num_limbs_r <= LIMB_INDEX_BITS'(1);
            iter_lim_r  <= 16'd0;
            cfg_pulse_r <= 1'b0;
        end else begin
            cfg_pulse_r <= cfg_accept_s;
            if (cfg_accept_s) begin
                num_limbs_r <= (cfg_num_limbs == {LIMB_INDEX_BITS{1'b0}}) ?
                               LIMB_INDEX_BITS'(1) : cfg_num_limbs;
                iter_lim_r  <= cfg_iter_lim;
            end
        end
    end

    // Dispatch FSM state register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= DISPATCH_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Dispatch FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DISPATCH_IDLE:  state_next_s = job_accept_s ? DISPATCH_LOAD : DISPATCH_IDLE;
            DISPATCH_LOAD:  state_next_s = last_beat_s ? DISPATCH_START : DISPATCH_LOAD;
            DISPATCH_START: state_next_s = DISPATCH_IDLE;
            default:        state_next_s = DISPATCH_IDLE;
        endcase
    end

    // Dispatch FSM outputs; jobs are held off while a config write is in progress
    always_comb begin
        job_ready_s  = 1'b0;
        limb_ready_s = 1'b0;
        wr_en_s      = {NUM_SOLVERS{1'b0}};
        start_s      = {NUM_SOLVERS{1'b0}};
        case (state_r)
            DISPATCH_IDLE: begin
                job_ready_s = reset && idle_valid_s && !cfg_accept_s && !cfg_pulse_r;
            end
            DISPATCH_LOAD: begin
                limb_ready_s = 1'b1;
                if (limb_valid) begin
                    wr_en_s = ONE_HOT_0 << slot_sel_r;
                end else begin
                    wr_en_s = {NUM_SOLVERS{1'b0}};
                end
            end
            DISPATCH_START: begin
                start_s = ONE_HOT_0 << slot_sel_r;
            end
            default: begin
                job_ready_s = 1'b0;
            end
        endcase
    end

    // Job acceptance bookkeeping: target slot, tag, limb counter, dispatch pointer
    always_ff @(posedge clock) begin
        if (!reset) begin
            slot_sel_r <= {IW{1'b0}};
            disp_ptr_r <= {IW{1'b0}};
            limb_cnt_r <= {LIMB_INDEX_BITS{1'b0}};
            for (int i = 0; i < NUM_SOLVERS; i++) begin
                tag_r[i] <= {TAG_BITS{1'b0}};
            end
        end else if (job_accept_s) begin
            slot_sel_r         <= idle_idx_s;
            disp_ptr_r         <= idle_idx_s + IW'(1);
            limb_cnt_r         <= {LIMB_INDEX_BITS{1'b0}};
            tag_r[idle_idx_s]  <= job_tag;
        end else if (limb_beat_s) begin
            limb_cnt_r <= limb_cnt_r + LIMB_INDEX_BITS'(1);
        end
    end

    // Delayed out_ready so only a fresh rising edge marks a core finished
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_ready_d_r <= {NUM_SOLVERS{1'b0}};
        end else begin
            out_ready_d_r <= sol_out_ready;
        end
    end

    // Per-slot lifecycle: IDLE -> LOADING -> BUSY -> DONE -> IDLE
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SOLVERS; i++) begin
            if (!reset) begin
                slot_r[i] <= SLOT_IDLE;
            end else begin
                case (slot_r[i])
                    SLOT_IDLE: begin
                        if (job_accept_s && idle_grant_s[i]) slot_r[i] <= SLOT_LOADING;
                    end
                    SLOT_LOADING: begin
                        if (state_r == DISPATCH_START && slot_sel_r == IW'(i)) slot_r[i] <= SLOT_BUSY;
                    end
                    SLOT_BUSY: begin
                        if (rise_s[i]) slot_r[i] <= SLOT_DONE;
                    end
                    SLOT_DONE: begin
                        if (load_res_s && done_grant_s[i]) slot_r[i] <= SLOT_IDLE;
                    end
                    default: slot_r[i] <= SLOT_IDLE;
                endcase
            end
        end
    end

    // Result register; count is sampled from the core only at load time
    always_ff @(posedge clock) begin
        if (!reset) begin
            res_valid_r <= 1'b0;
            res_tag_r   <= {TAG_BITS{1'b0}};
            res_count_r <= 16'd0;
            coll_ptr_r  <= {IW{1'b0}};
        end else if (load_res_s) begin
            res_valid_r <= 1'b1;
            res_tag_r   <= tag_r[done_idx_s];
            res_count_r <= sol_iter_count[COUNT_BITS*done_idx_s +: COUNT_BITS];
            coll_ptr_r  <= done_idx_s + IW'(1);
        end else if (res_free_s) begin
            res_valid_r <= 1'b0;
        end
    end

    assign cfg_busy            = cfg_busy_s;
    assign job_ready           = job_ready_s;
    assign limb_ready          = limb_ready_s;
    assign sol_wr_num_limbs_en = cfg_pulse_r;
    assign sol_wr_iter_lim_en  = cfg_pulse_r;
    assign sol_num_limbs       = num_limbs_r;
    assign sol_iter_lim        = iter_lim_r;
    assign sol_wr_en           = wr_en_s;
    assign sol_wr_limb         = limb_cnt_r;
    assign sol_cre             = limb_cre;
    assign sol_cim             = limb_cim;
    assign sol_start           = start_s;
    assign res_valid           = res_valid_r;
    assign res_tag             = res_tag_r;
    assign res_count           = res_count_r;

endmodule

// File: tb/tb_solver_dispatch.sv
// Directed self-checking bench for solver_dispatch; the bench plays the role
// of the solver cores by driving sol_out_ready and sol_iter_count directly.
module tb_solver_dispatch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_wr_en = 1'b0;
    logic [5:0]  cfg_num_limbs = 6'd0;
    logic [15:0] cfg_iter_lim = 16'd0;
    logic        cfg_busy;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [15:0] job_tag = 16'd0;
    logic        limb_valid = 1'b0;
    logic        limb_ready;
    logic [31:0] limb_cre = 32'd0;
    logic [31:0] limb_cim = 32'd0;
    logic        sol_wr_num_limbs_en;
    logic [5:0]  sol_num_limbs;
    logic        sol_wr_iter_lim_en;
    logic [15:0] sol_iter_lim;
    logic [3:0]  sol_wr_en;
    logic [5:0]  sol_wr_limb;
    logic [31:0] sol_cre;
    logic [31:0] sol_cim;
    logic [3:0]  sol_start;
    logic [3:0]  sol_out_ready = 4'd0;
    logic [63:0] sol_iter_count = 64'd0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_tag;
    logic [15:0] res_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    solver_dispatch dut (
        .clock(clock), .reset(reset),
        .cfg_wr_en(cfg_wr_en), .cfg_num_limbs(cfg_num_limbs), .cfg_iter_lim(cfg_iter_lim),
        .cfg_busy(cfg_busy),
        .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag),
        .limb_valid(limb_valid), .limb_ready(limb_ready), .limb_cre(limb_cre), .limb_cim(limb_cim),
        .sol_wr_num_limbs_en(sol_wr_num_limbs_en), .sol_num_limbs(sol_num_limbs),
        .sol_wr_iter_lim_en(sol_wr_iter_lim_en), .sol_iter_lim(sol_iter_lim),
        .sol_wr_en(sol_wr_en), .sol_wr_limb(sol_wr_limb), .sol_cre(sol_cre), .sol_cim(sol_cim),
        .sol_start(sol_start), .sol_out_ready(sol_out_ready), .sol_iter_count(sol_iter_count),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_count(res_count)
    );

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_res();
        for (int n = 0; n < 50 && !res_valid; n++) begin
            cyc();
            #1;
        end
        chk("res_wait", res_valid, 1'b1);
    endtask

    // Offer one job, stream nl limbs and confirm it lands on the expected slot
    task automatic do_job(input logic [15:0] tag, input int nl, input int slot);
        logic [3:0] oh;
        oh = 4'b0001 << slot;
        job_valid = 1'b1;
        job_tag   = tag;
        #1;
        for (int n = 0; n < 200 && !job_ready; n++) begin
            cyc();
            #1;
        end
        chk("job_ready", job_ready, 1'b1);
        cyc();
        job_valid = 1'b0;
        job_tag   = 16'h0000;
        for (int b = 0; b < nl; b++) begin
            limb_valid = 1'b1;
            limb_cre   = 32'hC0DE0000 | 32'(b);
            limb_cim   = 32'h00001100 | 32'(b);
            #1;
            chk("limb_ready", limb_ready, 1'b1);
            chk("job_ready_load", job_ready, 1'b0);
            chk("wr_en", sol_wr_en, oh);
            chk("wr_limb", sol_wr_limb, 6'(b));
            chk("cre_pass", sol_cre, 32'hC0DE0000 | 32'(b));
            chk("cim_pass", sol_cim, 32'h00001100 | 32'(b));
            cyc();
        end
        limb_valid = 1'b0;
        #1;
        chk("wr_en_after", sol_wr_en, 4'b0000);
        chk("start", sol_start, oh);
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        #1;
        chk("rst_job_ready", job_ready, 1'b0);
        chk("rst_limb_ready", limb_ready, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_wr_en", sol_wr_en, 4'b0000);
        chk("rst_start", sol_start, 4'b0000);
        chk("rst_pulse_nl", sol_wr_num_limbs_en, 1'b0);
        chk("rst_pulse_il", sol_wr_iter_lim_en, 1'b0);
        chk("rst_num_limbs", sol_num_limbs, 6'd1);
        chk("rst_iter_lim", sol_iter_lim, 16'd0);
        reset = 1'b1;
        cyc();

        // Configuration broadcast
        cfg_wr_en = 1'b1; cfg_num_limbs = 6'd3; cfg_iter_lim = 16'd100;
        #1;
        chk("cfg_busy_idle", cfg_busy, 1'b0);
        chk("job_ready_latch", job_ready, 1'b0);
        cyc();
        cfg_wr_en = 1'b0;
        #1;
        chk("pulse_nl", sol_wr_num_limbs_en, 1'b1);
        chk("pulse_il", sol_wr_iter_lim_en, 1'b1);
        chk("cfg_num_limbs", sol_num_limbs, 6'd3);
        chk("cfg_iter_lim", sol_iter_lim, 16'd100);
        chk("job_ready_pulse", job_ready, 1'b0);
        cyc();
        #1;
        chk("pulse_nl_end", sol_wr_num_limbs_en, 1'b0);
        chk("pulse_il_end", sol_wr_iter_lim_en, 1'b0);
        chk("cfg_busy_after", cfg_busy, 1'b0);
        chk("job_ready_after", job_ready, 1'b1);

        // Stray limbs while idle are not accepted
        limb_valid = 1'b1;
        #1;
        chk("limb_ready_idle", limb_ready, 1'b0);
        chk("wr_en_idle", sol_wr_en, 4'b0000);
        limb_valid = 1'b0;

        // Single job to slot 0
        do_job(16'h0042, 3, 0);
        cyc();
        #1;
        chk("start_one_cycle", sol_start, 4'b0000);
        chk("cfg_busy_busy", cfg_busy, 1'b1);
        sol_iter_count[15:0] = 16'd37;
        sol_out_ready[0] = 1'b1;
        wait_res();
        chk("res_tag_1", res_tag, 16'h0042);
        chk("res_count_1", res_count, 16'd37);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        #1;
        chk("res_popped_1", res_valid, 1'b0);

        // Fill all cores; core 0 keeps its old out_ready high, which must not count
        do_job(16'h0101, 3, 1);
        do_job(16'h0102, 3, 2);
        do_job(16'h0103, 3, 3);
        do_job(16'h0100, 3, 0);
        job_valid = 1'b1;
        job_tag   = 16'h0105;
        for (int n = 0; n < 3; n++) begin
            cyc();
            #1;
            chk("stall_ready", job_ready, 1'b0);
            chk("stall_no_res", res_valid, 1'b0);
        end
        sol_iter_count[47:32] = 16'd500;
        sol_out_ready[2] = 1'b1;
        do_job(16'h0105, 3, 2);
        chk("res_tag_2", res_tag, 16'h0102);
        chk("res_count_2", res_count, 16'd500);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        sol_out_ready[2] = 1'b0;
        #1;
        chk("res_popped_2", res_valid, 1'b0);

        // Cores 0 and 2 finish together under back-pressure
        sol_out_ready[0] = 1'b0;
        cyc();
        sol_iter_count[15:0]  = 16'h1111;
        sol_iter_count[47:32] = 16'hFFFF;
        sol_out_ready[0] = 1'b1;
        sol_out_ready[2] = 1'b1;
        cyc(); cyc();
        #1;
        chk("bp_valid", res_valid, 1'b1);
        chk("bp_tag", res_tag, 16'h0100);
        chk("bp_count", res_count, 16'h1111);
        sol_iter_count[15:0] = 16'hDEAD;
        for (int n = 0; n < 10; n++) begin
            cyc();
            #1;
            chk("hold_valid", res_valid, 1'b1);
            chk("hold_tag", res_tag, 16'h0100);
            chk("hold_count", res_count, 16'h1111);
        end
        res_ready = 1'b1;
        cyc();
        #1;
        chk("second_valid", res_valid, 1'b1);
        chk("second_tag", res_tag, 16'h0105);
        chk("limit_count", res_count, 16'hFFFF);
        cyc();
        #1;
        chk("no_dup", res_valid, 1'b0);
        res_ready = 1'b0;

        // Config write while cores 1 and 3 are busy is ignored
        cfg_wr_en = 1'b1; cfg_num_limbs = 6'd0; cfg_iter_lim = 16'd7;
        #1;
        chk("cfg_busy_high", cfg_busy, 1'b1);
        cyc();
        cfg_wr_en = 1'b0;
        #1;
        chk("ignored_pulse", sol_wr_num_limbs_en, 1'b0);
        chk("ignored_nl", sol_num_limbs, 6'd3);
        chk("ignored_il", sol_iter_lim, 16'd100);

        // Drain cores 1 and 3: collect pointer now favours slot 3
        sol_iter_count[31:16] = 16'h0011;
        sol_iter_count[63:48] = 16'h0033;
        sol_out_ready[1] = 1'b1;
        sol_out_ready[3] = 1'b1;
        res_ready = 1'b1;
        cyc(); cyc();
        #1;
        chk("drain_v1", res_valid, 1'b1);
        chk("drain_tag1", res_tag, 16'h0103);
        chk("drain_cnt1", res_count, 16'h0033);
        cyc();
        #1;
        chk("drain_v2", res_valid, 1'b1);
        chk("drain_tag2", res_tag, 16'h0101);
        chk("drain_cnt2", res_count, 16'h0011);
        cyc();
        #1;
        chk("drain_empty", res_valid, 1'b0);
        chk("all_idle", cfg_busy, 1'b0);
        res_ready = 1'b0;

        // Zero limbs clamps to one
        cfg_wr_en = 1'b1; cfg_num_limbs = 6'd0; cfg_iter_lim = 16'd200;
        cyc();
        cfg_wr_en = 1'b0;
        #1;
        chk("clamp_pulse", sol_wr_num_limbs_en, 1'b1);
        chk("clamp_nl", sol_num_limbs, 6'd1);
        chk("clamp_il", sol_iter_lim, 16'd200);
        cyc();
        do_job(16'h0200, 1, 3);
        cyc();
        sol_out_ready[3] = 1'b0;
        cyc();
        sol_iter_count[63:48] = 16'd9;
        sol_out_ready[3] = 1'b1;
        wait_res();
        chk("single_tag", res_tag, 16'h0200);
        chk("single_cnt", res_count, 16'd9);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;

        // Reset in the middle of a load
        job_valid = 1'b1;
        job_tag   = 16'h0300;
        #1;
        chk("job6_ready", job_ready, 1'b1);
        cyc();
        job_valid = 1'b0;
        #1;
        chk("job6_loading", limb_ready, 1'b1);
        reset = 1'b0;
        sol_out_ready = 4'b0000;
        cyc();
        #1;
        chk("mr_job_ready", job_ready, 1'b0);
        chk("mr_limb_ready", limb_ready, 1'b0);
        chk("mr_start", sol_start, 4'b0000);
        chk("mr_res_valid", res_valid, 1'b0);
        chk("mr_num_limbs", sol_num_limbs, 6'd1);
        chk("mr_iter_lim", sol_iter_lim, 16'd0);
        chk("mr_cfg_busy", cfg_busy, 1'b0);
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cyc();
            #1;
            chk("mr_no_start", sol_start, 4'b0000);
        end
        chk("mr_job_ready_after", job_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
